// File: rtl/hwalu_mac_pipe_if.sv
// Operand-beat and result handshake bundle for hwalu_mac_pipe.
// Latency: none; wires only.
// Backpressure: in_ready/out_ready; valids never depend on readies.
interface hwalu_mac_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        opcode;
  logic              ctrl;
  logic              accmu;
  logic [DATA_W-1:0] operanda;
  logic [DATA_W-1:0] operandb;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  result;
  logic              ovf;

  modport master (
    output in_valid, opcode, ctrl, accmu, operanda, operandb, out_ready,
    input  in_ready, out_valid, result, ovf
  );

  modport slave (
    input  in_valid, opcode, ctrl, accmu, operanda, operandb, out_ready,
    output in_ready, out_valid, result, ovf
  );
endinterface

// File: rtl/hwalu_mac_pipe.sv
// Pipelined MAC: muladd, dot8, dot16, complex, with optional accumulate and saturation.
// Latency: beat accepted at edge k gives result/out_valid after edge k+3.
// Backpressure: one global enable (~out_valid | out_ready) freezes every stage and acc.
module hwalu_mac_pipe #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64,
  parameter bit SAT    = 1'b0
) (
  input logic             clk,
  input logic             rst,
  hwalu_mac_pipe_if.slave bus
);
  localparam int N8   = DATA_W / 8;
  localparam int N16  = DATA_W / 16;
  localparam int H    = DATA_W / 2;
  localparam int M_W  = 2 * DATA_W;
  localparam int R_W  = DATA_W + 1;
  localparam int F_W  = ACC_W / 2;
  localparam int FX_W = F_W + 2;
  localparam int AX_W = ACC_W + 2;

  localparam logic [1:0] OP_MULADD = 2'b00;
  localparam logic [1:0] OP_DOT8   = 2'b01;
  localparam logic [1:0] OP_CPLX   = 2'b10;
  localparam logic [1:0] OP_DOT16  = 2'b11;

  logic en;

  // Stage 1: captured operands and controls
  logic              s1_vld;
  logic [1:0]        s1_op;
  logic              s1_ctrl;
  logic              s1_accmu;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;

  // Stage 2: lane products for every mode
  logic                     s2_vld;
  logic [1:0]               s2_op;
  logic                     s2_ctrl;
  logic                     s2_accmu;
  logic signed [M_W-1:0]    s2_mul;
  logic signed [15:0]       s2_p8  [N8];
  logic signed [31:0]       s2_p16 [N16];
  logic signed [DATA_W-1:0] s2_rr;
  logic signed [DATA_W-1:0] s2_ii;
  logic signed [DATA_W-1:0] s2_ir;
  logic signed [DATA_W-1:0] s2_ri;

  // Stage 3 front half: reduced lane sums, kept apart from the accumulate adder
  logic                    sr_vld;
  logic                    sr_cplx;
  logic                    sr_accmu;
  logic signed [ACC_W-1:0] sr_p;
  logic signed [R_W-1:0]   sr_re;
  logic signed [R_W-1:0]   sr_im;

  // Stage 3 back half: accumulator, which is also the visible result
  logic             s3_vld;
  logic [ACC_W-1:0] acc;
  logic             ovf_q;

  logic signed [ACC_W-1:0] p_lin;
  logic signed [R_W-1:0]   re_p;
  logic signed [R_W-1:0]   im_p;

  logic [ACC_W-1:0]       base;
  logic signed [AX_W-1:0] full_sum;
  logic signed [FX_W-1:0] hi_sum;
  logic signed [FX_W-1:0] lo_sum;
  logic                   ovf_full;
  logic                   ovf_hi;
  logic                   ovf_lo;
  logic [ACC_W-1:0]       full_fit;
  logic [F_W-1:0]         hi_fit;
  logic [F_W-1:0]         lo_fit;
  logic [ACC_W-1:0]       acc_nxt;
  logic                   beat_ovf;
  logic                   ovf_nxt;

  assign en            = ~s3_vld | bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = s3_vld;
  assign bus.result    = acc;
  assign bus.ovf       = ovf_q;

  // Valid chain plus accumulator; bubbles travel as invalid slots and never touch acc
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      sr_vld <= 1'b0;
      s3_vld <= 1'b0;
      acc    <= '0;
      ovf_q  <= 1'b0;
    end else if (en) begin
      s1_vld <= bus.in_valid;
      s2_vld <= s1_vld;
      sr_vld <= s2_vld;
      s3_vld <= sr_vld;
      if (sr_vld) begin
        acc   <= acc_nxt;
        ovf_q <= ovf_nxt;
      end
    end
  end

  // Stage 1 data: operands and controls ride along with the beat
  always_ff @(posedge clk) begin
    if (en && bus.in_valid) begin
      s1_op    <= bus.opcode;
      s1_ctrl  <= bus.ctrl;
      s1_accmu <= bus.accmu;
      s1_a     <= bus.operanda;
      s1_b     <= bus.operandb;
    end
  end

  // Stage 2 data: all products are formed; the reduction picks by opcode
  always_ff @(posedge clk) begin
    if (en && s1_vld) begin
      s2_op    <= s1_op;
      s2_ctrl  <= s1_ctrl;
      s2_accmu <= s1_accmu;
      s2_mul   <= M_W'($signed(s1_a)) * M_W'($signed(s1_b));
      for (int i = 0; i < N8; i++)
        s2_p8[i] <= 16'($signed(s1_a[8*i +: 8])) * 16'($signed(s1_b[8*i +: 8]));
      for (int i = 0; i < N16; i++)
        s2_p16[i] <= 32'($signed(s1_a[16*i +: 16])) * 32'($signed(s1_b[16*i +: 16]));
      s2_rr <= DATA_W'($signed(s1_a[DATA_W-1:H])) * DATA_W'($signed(s1_b[DATA_W-1:H]));
      s2_ii <= DATA_W'($signed(s1_a[H-1:0]))      * DATA_W'($signed(s1_b[H-1:0]));
      s2_ir <= DATA_W'($signed(s1_a[H-1:0]))      * DATA_W'($signed(s1_b[DATA_W-1:H]));
      s2_ri <= DATA_W'($signed(s1_a[DATA_W-1:H])) * DATA_W'($signed(s1_b[H-1:0]));
    end
  end

  // Collapse lane products into one linear sum and a re/im pair (ctrl picks conjugate)
  always_comb begin
    p_lin = '0;
    case (s2_op)
      OP_MULADD: p_lin = ACC_W'(s2_mul);
      OP_DOT8: begin
        for (int i = 0; i < N8; i++) p_lin = p_lin + ACC_W'(s2_p8[i]);
      end
      OP_DOT16: begin
        for (int i = 0; i < N16; i++) p_lin = p_lin + ACC_W'(s2_p16[i]);
      end
      default: p_lin = '0;
    endcase
    if (s2_ctrl) begin
      re_p = R_W'(s2_rr) + R_W'(s2_ii);
      im_p = R_W'(s2_ir) - R_W'(s2_ri);
    end else begin
      re_p = R_W'(s2_rr) - R_W'(s2_ii);
      im_p = R_W'(s2_ir) + R_W'(s2_ri);
    end
  end

  // Register the reduced sums so the adder tree and the saturating add sit in separate cycles
  always_ff @(posedge clk) begin
    if (en && s2_vld) begin
      sr_cplx  <= (s2_op == OP_CPLX);
      sr_accmu <= s2_accmu;
      sr_p     <= p_lin;
      sr_re    <= re_p;
      sr_im    <= im_p;
    end
  end

  // Accumulate with two guard bits: full width, or two independent fields for complex
  always_comb begin
    base     = sr_accmu ? acc : '0;
    full_sum = AX_W'($signed(base)) + AX_W'(sr_p);
    hi_sum   = FX_W'($signed(base[ACC_W-1:F_W])) + FX_W'(sr_re);
    lo_sum   = FX_W'($signed(base[F_W-1:0])) + FX_W'(sr_im);
    ovf_full = full_sum[AX_W-1:ACC_W-1] != {3{full_sum[AX_W-1]}};
    ovf_hi   = hi_sum[FX_W-1:F_W-1] != {3{hi_sum[FX_W-1]}};
    ovf_lo   = lo_sum[FX_W-1:F_W-1] != {3{lo_sum[FX_W-1]}};
    full_fit = (SAT && ovf_full) ? {full_sum[AX_W-1], {(ACC_W-1){~full_sum[AX_W-1]}}}
                                 : full_sum[ACC_W-1:0];
    hi_fit   = (SAT && ovf_hi) ? {hi_sum[FX_W-1], {(F_W-1){~hi_sum[FX_W-1]}}} : hi_sum[F_W-1:0];
    lo_fit   = (SAT && ovf_lo) ? {lo_sum[FX_W-1], {(F_W-1){~lo_sum[FX_W-1]}}} : lo_sum[F_W-1:0];
    if (sr_cplx) begin
      acc_nxt  = {hi_fit, lo_fit};
      beat_ovf = ovf_hi | ovf_lo;
    end else begin
      acc_nxt  = full_fit;
      beat_ovf = ovf_full;
    end
    ovf_nxt = beat_ovf | (sr_accmu & ovf_q);
  end
endmodule

// File: tb/tb_hwalu_mac_pipe.sv
// Directed bench for hwalu_mac_pipe: default 32/64 wrap instance and a 16/32 saturating one.
// Latency: results expected 3 edges after each accepted beat.
// Backpressure: out_ready stalls exercised on the default instance.
module tb_hwalu_mac_pipe;
  localparam logic [1:0] MULADD = 2'b00;
  localparam logic [1:0] DOT8   = 2'b01;
  localparam logic [1:0] CPLX   = 2'b10;
  localparam logic [1:0] DOT16  = 2'b11;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  hwalu_mac_pipe_if #(.DATA_W(32), .ACC_W(64)) m0 ();
  hwalu_mac_pipe_if #(.DATA_W(16), .ACC_W(32)) m1 ();

  hwalu_mac_pipe #(.DATA_W(32), .ACC_W(64), .SAT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(m0.slave));
  hwalu_mac_pipe #(.DATA_W(16), .ACC_W(32), .SAT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(m1.slave));

  logic [64:0] q0 [$];
  logic [64:0] q1 [$];

  // Record every transferred result with its ovf flag
  always @(posedge clk) begin
    if (m0.out_valid && m0.out_ready) q0.push_back({m0.ovf, m0.result});
    if (m1.out_valid && m1.out_ready) q1.push_back({m1.ovf, 32'h0, m1.result});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic send(input bit sel, input logic [1:0] op, input logic c, input logic am,
                      input logic [31:0] a, input logic [31:0] b);
    int   n  = 0;
    logic ok = 1'b0;
    if (sel) begin
      m1.in_valid = 1'b1; m1.opcode = op; m1.ctrl = c; m1.accmu = am;
      m1.operanda = a[15:0]; m1.operandb = b[15:0];
    end else begin
      m0.in_valid = 1'b1; m0.opcode = op; m0.ctrl = c; m0.accmu = am;
      m0.operanda = a; m0.operandb = b;
    end
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = sel ? m1.in_ready : m0.in_ready;
      @(posedge clk); #1;
      n++;
    end
    m0.in_valid = 1'b0;
    m1.in_valid = 1'b0;
    chk1("send_accepted", ok, 1'b1);
  endtask

  task automatic expect_res(input bit sel, input string tag, input logic [63:0] er, input logic eo);
    int          n = 0;
    int          sz;
    logic [64:0] e;
    sz = sel ? q1.size() : q0.size();
    while (n < 40 && sz == 0) begin
      @(posedge clk); #1;
      n++;
      sz = sel ? q1.size() : q0.size();
    end
    chk1({tag, "_present"}, sz != 0, 1'b1);
    if (sz != 0) begin
      if (sel) e = q1.pop_front();
      else     e = q0.pop_front();
      chk({tag, "_result"}, e[63:0], er);
      chk1({tag, "_ovf"}, e[64], eo);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    m0.in_valid = 1'b0; m0.opcode = 2'b00; m0.ctrl = 1'b0; m0.accmu = 1'b0;
    m0.operanda = '0; m0.operandb = '0; m0.out_ready = 1'b1;
    m1.in_valid = 1'b0; m1.opcode = 2'b00; m1.ctrl = 1'b0; m1.accmu = 1'b0;
    m1.operanda = '0; m1.operandb = '0; m1.out_ready = 1'b1;
    #1;
    chk1("rst0_out_valid", m0.out_valid, 1'b0);
    chk ("rst0_result", m0.result, 64'h0);
    chk1("rst0_ovf", m0.ovf, 1'b0);
    chk1("rst0_in_ready", m0.in_ready, 1'b1);
    chk1("rst1_out_valid", m1.out_valid, 1'b0);
    chk ("rst1_result", 64'(m1.result), 64'h0);
    chk1("rst1_in_ready", m1.in_ready, 1'b1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // muladd with exact latency: beats at edges k and k+1
    send(1'b0, MULADD, 1'b0, 1'b0, 32'h000001ff, 32'h000001ff);
    send(1'b0, MULADD, 1'b0, 1'b1, 32'h00300001, 32'h00200001);
    chk1("lat_k1_valid", m0.out_valid, 1'b0);
    @(posedge clk); #1;
    chk1("lat_k2_valid", m0.out_valid, 1'b0);
    @(posedge clk); #1;
    chk1("lat_k3_valid", m0.out_valid, 1'b1);
    chk ("lat_k3_result", m0.result, 64'h3fc01);
    @(posedge clk); #1;
    chk1("lat_k4_valid", m0.out_valid, 1'b1);
    chk ("lat_k4_result", m0.result, 64'h600_0053_fc02);
    @(posedge clk); #1;
    chk1("lat_k5_valid", m0.out_valid, 1'b0);
    expect_res(1'b0, "muladd_load", 64'h3fc01, 1'b0);
    expect_res(1'b0, "muladd_acc", 64'h600_0053_fc02, 1'b0);

    // dot8 and dot16
    send(1'b0, DOT8,  1'b0, 1'b0, 32'h01020304, 32'h05060708);
    send(1'b0, DOT8,  1'b0, 1'b1, 32'h000000ff, 32'h00000002);
    send(1'b0, DOT16, 1'b0, 1'b0, 32'h00020003, 32'h00040005);
    send(1'b0, DOT16, 1'b0, 1'b1, 32'hffff0001, 32'h00030002);
    expect_res(1'b0, "dot8_load", 64'h46, 1'b0);
    expect_res(1'b0, "dot8_acc", 64'h44, 1'b0);
    expect_res(1'b0, "dot16_load", 64'h17, 1'b0);
    expect_res(1'b0, "dot16_acc", 64'h16, 1'b0);

    // complex, plain and conjugate, then a field accumulate with no borrow into re
    send(1'b0, CPLX, 1'b0, 1'b0, 32'h00020003, 32'h00040005);
    send(1'b0, CPLX, 1'b1, 1'b0, 32'h00020003, 32'h00040005);
    send(1'b0, CPLX, 1'b0, 1'b1, 32'h00010000, 32'h0000fffd);
    expect_res(1'b0, "cplx_plain", 64'hFFFFFFF9_00000016, 1'b0);
    expect_res(1'b0, "cplx_conj", 64'h00000017_00000002, 1'b0);
    expect_res(1'b0, "cplx_fields", 64'h00000017_FFFFFFFF, 1'b0);

    // wrap instance: overflow wraps, ovf sticks through accmu=1, clears on clean load
    send(1'b0, MULADD, 1'b0, 1'b0, 32'h80000000, 32'h80000000);
    send(1'b0, MULADD, 1'b0, 1'b1, 32'h80000000, 32'h80000000);
    send(1'b0, MULADD, 1'b0, 1'b1, 32'h00000000, 32'h00000000);
    send(1'b0, MULADD, 1'b0, 1'b0, 32'h00000001, 32'h00000001);
    expect_res(1'b0, "wrap_load", 64'h4000_0000_0000_0000, 1'b0);
    expect_res(1'b0, "wrap_over", 64'h8000_0000_0000_0000, 1'b1);
    expect_res(1'b0, "wrap_sticky", 64'h8000_0000_0000_0000, 1'b1);
    expect_res(1'b0, "wrap_clear", 64'h1, 1'b0);

    // saturating instance: clamp to max and min
    send(1'b1, MULADD, 1'b0, 1'b0, 32'h8000, 32'h8000);
    send(1'b1, MULADD, 1'b0, 1'b1, 32'h8000, 32'h8000);
    send(1'b1, MULADD, 1'b0, 1'b1, 32'h8000, 32'h8000);
    send(1'b1, MULADD, 1'b0, 1'b0, 32'h8000, 32'h8000);
    send(1'b1, MULADD, 1'b0, 1'b0, 32'h8000, 32'h7fff);
    send(1'b1, MULADD, 1'b0, 1'b1, 32'h8000, 32'h7fff);
    send(1'b1, MULADD, 1'b0, 1'b1, 32'h8000, 32'h7fff);
    expect_res(1'b1, "sat_load", 64'h40000000, 1'b0);
    expect_res(1'b1, "sat_max1", 64'h7FFFFFFF, 1'b1);
    expect_res(1'b1, "sat_max2", 64'h7FFFFFFF, 1'b1);
    expect_res(1'b1, "sat_clear", 64'h40000000, 1'b0);
    expect_res(1'b1, "sat_neg_load", 64'hC0008000, 1'b0);
    expect_res(1'b1, "sat_neg_acc", 64'h80010000, 1'b0);
    expect_res(1'b1, "sat_min", 64'h80000000, 1'b1);

    // backpressure: out_ready low for 5 edges while 4 beats are offered
    m0.out_ready = 1'b0;
    fork
      begin
        send(1'b0, MULADD, 1'b0, 1'b0, 32'd1, 32'd10);
        send(1'b0, MULADD, 1'b0, 1'b1, 32'd2, 32'd10);
        send(1'b0, MULADD, 1'b0, 1'b1, 32'd3, 32'd10);
        send(1'b0, MULADD, 1'b0, 1'b1, 32'd4, 32'd10);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        chk1("bp_e4_in_ready", m0.in_ready, 1'b0);
        chk1("bp_e4_valid", m0.out_valid, 1'b1);
        chk ("bp_e4_result", m0.result, 64'd10);
        @(posedge clk); #1;
        chk1("bp_e5_in_ready", m0.in_ready, 1'b0);
        chk ("bp_e5_result_hold", m0.result, 64'd10);
        chk1("bp_e5_no_transfer", q0.size() == 0, 1'b1);
        m0.out_ready = 1'b1;
      end
    join
    expect_res(1'b0, "bp_r0", 64'd10, 1'b0);
    expect_res(1'b0, "bp_r1", 64'd30, 1'b0);
    expect_res(1'b0, "bp_r2", 64'd60, 1'b0);
    expect_res(1'b0, "bp_r3", 64'd100, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    chk1("bp_no_duplicate", q0.size() == 0, 1'b1);

    // reset with two beats in flight
    send(1'b0, MULADD, 1'b0, 1'b1, 32'd7, 32'd7);
    send(1'b0, MULADD, 1'b0, 1'b1, 32'd7, 32'd7);
    #2;
    rst = 1'b0;
    #1;
    chk1("midrst_out_valid", m0.out_valid, 1'b0);
    chk ("midrst_result", m0.result, 64'h0);
    chk1("midrst_ovf", m0.ovf, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk1("postrst_in_ready", m0.in_ready, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    chk1("postrst_no_output", q0.size() == 0, 1'b1);
    send(1'b0, MULADD, 1'b0, 1'b1, 32'd3, 32'd4);
    expect_res(1'b0, "postrst_acc_from0", 64'd12, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
